// File: rtl/event_collector_if.sv
// Bus between the event filter, the event collector and the output pins.
//   x_in, y_in, p_in, t_in : 2-bit fields of the filtered event word
//                            (all zero means no event this cycle)
//   out_data               : 8-bit stream byte
//   out_valid, out_ready   : stream handshake
// Handshake: a byte moves on every rising edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data holds its value.
// Once raised, out_valid stays high until the packet's last byte moves.
// The slave modport is the collector; the master is whoever drives events
// and consumes the stream.
interface event_collector_if;
  logic [1:0] x_in;
  logic [1:0] y_in;
  logic [1:0] p_in;
  logic [1:0] t_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output x_in, y_in, p_in, t_in, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  x_in, y_in, p_in, t_in, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/event_collector.sv
// Event collector: captures every nonzero filtered event word into a small
// FIFO and sends each entry as a 2-byte packet: {HDR_NIB, seq} then the event.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : event inputs and 8-bit valid/ready output stream (slave side)
//   fifo_level : current FIFO occupancy (0..DEPTH)
//   overflow   : sticky, set when an event is dropped on a full FIFO
//   drop_cnt   : dropped-event count, saturates at 255
//   dbg_state  : current packetiser state (IDLE=0, HDR=1, DATA=2)
module event_collector #(
  parameter int         DEPTH   = 4,
  parameter logic [3:0] HDR_NIB = 4'hA
) (
  input  logic                     clk,
  input  logic                     rst,
  event_collector_if.slave         bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic [1:0]               dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    seq;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [7:0]    ev;
  logic          ev_present;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [LW-1:0] level_next;

  always_comb begin
    ev         = {bus.x_in, bus.y_in, bus.p_in, bus.t_in};
    ev_present = (ev != 8'h00);
    full       = (fifo_level == LW'(DEPTH));
    // The head is only ever released in DATA, so a header and its event
    // byte always come from the same entry.
    pop        = (state == S_DATA) && bus.out_ready;
    // A pop on the same edge frees the slot that a full FIFO needs.
    push       = ev_present && (!full || pop);
    drop       = ev_present && full && !pop;
    level_next = fifo_level + LW'(push) - LW'(pop);
  end

  // Storage has no reset; emptiness is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= ev;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_level <= level_next;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

  // Packetiser. out_valid/out_data are loaded together with the state so
  // the stream is driven purely from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      seq           <= 4'd0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          // level_next includes this edge's push, so a fresh event shows its
          // header on the very next cycle.
          if (level_next != '0) begin
            state         <= S_HDR;
            bus.out_valid <= 1'b1;
            bus.out_data  <= {HDR_NIB, seq};
          end
        end
        S_HDR: begin
          if (bus.out_ready) begin
            state        <= S_DATA;
            bus.out_data <= mem[rd_ptr];
          end
        end
        S_DATA: begin
          if (bus.out_ready) begin
            seq <= seq + 4'd1;
            if (level_next != '0) begin
              state        <= S_HDR;
              bus.out_data <= {HDR_NIB, seq + 4'd1};
            end else begin
              state         <= S_IDLE;
              bus.out_valid <= 1'b0;
              bus.out_data  <= 8'h00;
            end
          end
        end
        default: begin
          state         <= S_IDLE;
          bus.out_valid <= 1'b0;
          bus.out_data  <= 8'h00;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_event_collector.sv
// Directed bench for event_collector: a per-cycle vector table for the
// single-event and back-pressure cases, then hand-written sequences for
// overflow, seq wrap, full-with-pop, mid-packet reset and zero words.
module tb_event_collector;

  logic       clk;
  logic       rst;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic [1:0] dbg_state;

  event_collector_if bus ();

  event_collector #(.DEPTH(4), .HDR_NIB(4'hA)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic [7:0] ev;
    logic       ready;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_level;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [7:0] e, input logic rdy,
                     input logic v, input logic [7:0] d, input logic [2:0] l);
    vec_t t;
    t.rst = r; t.ev = e; t.ready = rdy;
    t.e_valid = v; t.e_data = d; t.e_level = l;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic set_ev(input logic [7:0] e);
    bus.x_in = e[7:6];
    bus.y_in = e[5:4];
    bus.p_in = e[3:2];
    bus.t_in = e[1:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_ev(8'h00);
    step();
    rst = 1'b0;
  endtask

  // Consume the stream with ready high, checking every transferred byte
  // against exp_q; bounded by max_cycles.
  task automatic drain(input string name, input int max_cycles);
    bus.out_ready = 1'b1;
    set_ev(8'h00);
    for (int c = 0; c < max_cycles && (exp_q.size() != 0 || bus.out_valid); c++) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk({name, "_extra_byte"}, {24'h0, bus.out_data}, 32'hFFFF_FFFF);
        end else begin
          chk({name, "_byte"}, {24'h0, bus.out_data}, {24'h0, exp_q.pop_front()});
        end
      end
      step();
    end
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_idle_valid"}, bus.out_valid, 1'b0);
    chk({name, "_idle_level"}, fifo_level, 3'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.out_ready = 1'b0;
    set_ev(8'h00);

    // vector table: inputs for one cycle, outputs expected after that edge
    add(1, 8'h00, 1, 0, 8'h00, 0);
    add(0, 8'h67, 1, 1, 8'hA0, 1); // x=1,y=2,p=1,t=3
    add(0, 8'h00, 1, 1, 8'h67, 1);
    add(0, 8'h00, 1, 0, 8'h00, 0);
    add(1, 8'h00, 1, 0, 8'h00, 0);
    add(0, 8'h5A, 0, 1, 8'hA0, 1); // back-pressure: 5 cycles with ready low
    add(0, 8'h00, 0, 1, 8'hA0, 1);
    add(0, 8'h00, 0, 1, 8'hA0, 1);
    add(0, 8'h00, 0, 1, 8'hA0, 1);
    add(0, 8'h00, 0, 1, 8'hA0, 1);
    add(0, 8'h00, 1, 1, 8'h5A, 1);
    add(0, 8'h00, 1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      set_ev(vecs[i].ev);
      bus.out_ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d_valid", i), bus.out_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_data", i), bus.out_data, vecs[i].e_data);
      chk($sformatf("vec%0d_level", i), fifo_level, vecs[i].e_level);
      chk($sformatf("vec%0d_ovf", i), overflow, 1'b0);
    end
    rst = 1'b0;

    // overflow: 7 events with ready low, 4 kept, 3 dropped
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      set_ev(8'(i * 8'h11));
      step();
    end
    set_ev(8'h00);
    chk("ovf_level", fifo_level, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_drop_cnt", drop_cnt, 8'd3);
    chk("ovf_hdr_valid", bus.out_valid, 1'b1);
    chk("ovf_hdr_data", bus.out_data, 8'hA0);
    exp_q = '{8'hA0, 8'h11, 8'hA1, 8'h22, 8'hA2, 8'h33, 8'hA3, 8'h44};
    drain("ovf", 40);
    chk("ovf_flag_sticky", overflow, 1'b1);
    chk("ovf_drop_cnt_kept", drop_cnt, 8'd3);

    // seq wrap: 17 events, ready high, 3 cycles apart
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      logic [3:0] s;
      s = 4'(i);
      set_ev(8'(i + 1));
      step();
      set_ev(8'h00);
      chk($sformatf("wrap%0d_hdr", i), bus.out_data, {4'hA, s});
      step();
      chk($sformatf("wrap%0d_data", i), bus.out_data, 8'(i + 1));
      step();
      chk($sformatf("wrap%0d_idle", i), bus.out_valid, 1'b0);
    end

    // full FIFO with a pop on the same edge as a new event
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_ev(8'(8'h80 + i));
      step();
    end
    set_ev(8'h00);
    bus.out_ready = 1'b1;
    step();
    chk("fullpop_in_data", bus.out_data, 8'h81);
    chk("fullpop_level_before", fifo_level, 3'd4);
    set_ev(8'h85);
    step();
    set_ev(8'h00);
    chk("fullpop_level", fifo_level, 3'd4);
    chk("fullpop_drop_cnt", drop_cnt, 8'd0);
    chk("fullpop_ovf", overflow, 1'b0);
    exp_q = '{8'hA1, 8'h82, 8'hA2, 8'h83, 8'hA3, 8'h84, 8'hA4, 8'h85};
    drain("fullpop", 40);

    // reset mid-packet, with overflow set and an event in the reset cycle
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_ev(8'(8'h30 + i));
      step();
    end
    set_ev(8'h00);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("rstmid_in_data", bus.out_data, 8'h31);
    chk("rstmid_ovf_before", overflow, 1'b1);
    rst = 1'b1;
    set_ev(8'h44);
    step();
    rst = 1'b0;
    set_ev(8'h00);
    chk("rstmid_valid", bus.out_valid, 1'b0);
    chk("rstmid_data", bus.out_data, 8'h00);
    chk("rstmid_level", fifo_level, 3'd0);
    chk("rstmid_ovf", overflow, 1'b0);
    chk("rstmid_drop_cnt", drop_cnt, 8'd0);
    step();
    chk("rstmid_discard_valid", bus.out_valid, 1'b0);
    chk("rstmid_discard_level", fifo_level, 3'd0);
    bus.out_ready = 1'b1;
    set_ev(8'h12);
    step();
    set_ev(8'h00);
    chk("rstmid_new_hdr", bus.out_data, 8'hA0);
    step();
    chk("rstmid_new_data", bus.out_data, 8'h12);
    step();
    chk("rstmid_new_idle", bus.out_valid, 1'b0);

    // zero words are never captured
    for (int i = 0; i < 10; i++) begin
      set_ev(8'h00);
      step();
      chk($sformatf("zero%0d_valid", i), bus.out_valid, 1'b0);
      chk($sformatf("zero%0d_level", i), fifo_level, 3'd0);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_collector.md
Name: event_collector

Overview:
- Sink for the event filter's output bus. Captures each filtered event, meaning any cycle where the packed {x,y,p,t} word is nonzero, and buffers it in a small FIFO.
- Emits each buffered event as a 2-byte packet on an 8-bit valid/ready stream: a header byte carrying a sequence number, then the event byte.
- Sits between the filter and the off-chip output pins.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- HDR_NIB, 4'hA, constant upper nibble of every header byte.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- x_in  input  2  event x coordinate from filter.
- y_in  input  2  event y coordinate from filter.
- t_in  input  2  event timestamp from filter.
- p_in  input  2  event polarity from filter.
- out_data  output  8  stream byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts byte when high together with out_valid.
- fifo_level  output  log2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag; set when an event is dropped.
- drop_cnt  output  8  count of dropped events; saturates at 255.

Behaviour:
- Event word ev = {x_in, y_in, p_in, t_in}, 8 bits, x in bits [7:6].
- An event is present when ev != 8'h00. An all-zero word is never an event and is never captured.
- Each nonzero cycle is one event; consecutive nonzero cycles are separate events.
- Capture: ev is sampled on the rising edge. If the FIFO is not full, ev is pushed and fifo_level increments the same edge.
- Full-FIFO drop: if the FIFO is full and no pop occurs that edge, the event is dropped. overflow sets to 1; drop_cnt increments unless already 255.
- Simultaneous push and pop while full: the pop frees a slot, the push is accepted, fifo_level stays at DEPTH, and nothing is dropped.
- FSM states: IDLE, HDR, DATA.
  - IDLE: out_valid=0. If the FIFO is non-empty, go to HDR.
  - HDR: out_valid=1, out_data={HDR_NIB, seq[3:0]}. On out_valid&&out_ready, go to DATA.
  - DATA: out_valid=1, out_data=FIFO head. On out_valid&&out_ready: pop the head, seq<=seq+1 (wraps 15->0), then go to HDR if the FIFO still holds another entry after this pop, else IDLE.
- Stream rules:
  - out_data and out_valid are driven directly from registered state, seq and the FIFO head; no combinational path from inputs to outputs.
  - out_data stays stable while out_valid=1 and out_ready=0.
  - out_valid never drops mid-packet except on rst.
- Latency: event present in cycle N is pushed at edge N. If the FSM was IDLE, the header is presented from cycle N+1 and the data byte follows on the cycle after header acceptance.
- Back-to-back: with out_ready held high, each event takes 2 cycles, HDR then DATA; there are no IDLE bubbles while the FIFO is non-empty.
- Packet atomicity: the FIFO head is never popped in HDR. The header and its event byte always belong to the same entry.
- Reset, whether idle or mid-packet:
  - state=IDLE, FIFO emptied, fifo_level=0, seq=0, overflow=0, drop_cnt=0, out_valid=0, out_data=8'h00.
  - A partially sent packet is abandoned.
  - An event present in the rst cycle is discarded.
- out_data is 8'h00 in IDLE.

Test Plan:
- Single event, out_ready=1: x=1,y=2,p=1,t=3 for one cycle -> next cycle out_data=8'hA0 valid, then 8'h67, then out_valid=0; fifo_level returns to 0.
- Back-pressure: one event 8'h5A, out_ready=0 for 5 cycles -> out_data holds 8'hA0 with out_valid=1 throughout; raise out_ready -> 8'h5A, then IDLE.
- Overflow, DEPTH=4, out_ready=0: 7 consecutive nonzero events -> 4 stored, overflow=1, drop_cnt=3; release ready -> exactly 4 packets, seq 0..3, in arrival order.
- Seq wrap: 17 events, ready high, spaced 3 cycles apart -> headers A0..AF, then A0 for the 17th packet.
- Full plus simultaneous pop: FIFO full, in DATA with out_ready=1, new event same cycle -> event accepted, drop_cnt unchanged, fifo_level stays 4.
- Reset mid-packet: assert rst while in DATA with 3 queued -> next cycle out_valid=0, fifo_level=0, overflow=0; a subsequent event produces header 8'hA0.
- Zero word ignored: drive ev=8'h00 for 10 cycles -> no push, out_valid stays 0.
